m68k_bus_ctrl: RTL and testbench

- Bus-cycle sequencer for the 68000 local bus.
- Decodes the address of each AS-qualified cycle into boot ROM, external SRAM, peripheral space or unmapped space.
- Inserts per-region wait states, then drives DTACKn, BERRn, the data-buffer direction, and SRAM/peripheral strobes.
- Replaces the fixed "AS low → DTACK next cycle" logic in the top level; top level keeps the ROM array and data mux.

---
 rtl/m68k_bus_pkg.sv | 54 +++++
 rtl/m68k_bus_ctrl_if.sv | 32 +++
 rtl/m68k_addr_decode.sv | 25 ++
 rtl/m68k_bus_ctrl.sv | 169 ++++++++++++++++
 tb/tb_m68k_bus_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared types and address-map constants for the 68000 local-bus sequencer
// and any other master that needs to classify bus addresses.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_ACK,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        REG_ROM,
        REG_SRAM,
        REG_PERIPH,
        REG_UNMAPPED
    } region_t;

    typedef struct packed {
        logic       dtack_n;
        logic       berr_n;
        logic       dir;
        logic       rom_sel;
        logic       periph_cs;
        logic       sram_ce_n;
        logic       sram_oe_n;
        logic [1:0] sram_we_n;
    } bus_out_t;

    localparam bus_out_t OUT_IDLE = '{
        dtack_n:   1'b1,
        berr_n:    1'b1,
        dir:       1'b0,
        rom_sel:   1'b0,
        periph_cs: 1'b0,
        sram_ce_n: 1'b1,
        sram_oe_n: 1'b1,
        sram_we_n: 2'b11
    };

    // Map expressed on byte addresses: region hit when (addr & MASK) == BASE.
    localparam logic [23:0] ROM_BASE    = 24'h000000;
    localparam logic [23:0] ROM_MASK    = 24'hFFF800;
    localparam logic [23:0] SRAM_BASE   = 24'h100000;
    localparam logic [23:0] SRAM_MASK   = 24'hF80000;
    localparam logic [23:0] PERIPH_BASE = 24'hF00000;
    localparam logic [23:0] PERIPH_MASK = 24'hF00000;

    localparam int unsigned DEF_ROM_WAIT       = 0;
    localparam int unsigned DEF_SRAM_WAIT      = 1;
    localparam int unsigned DEF_PERIPH_TIMEOUT = 255;

endpackage

// File: rtl/m68k_bus_ctrl_if.sv
// CPU-side local-bus signals seen by the bus sequencer.
interface m68k_bus_ctrl_if;

    logic        as_n;
    logic        r_wn;
    logic        uds_n;
    logic        lds_n;
    logic [23:1] addr;
    logic        periph_ack;

    logic        dtack_n;
    logic        berr_n;
    logic        dir;
    logic        rom_sel;
    logic        periph_cs;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic [1:0]  sram_we_n;

    modport master (
        output as_n, r_wn, uds_n, lds_n, addr, periph_ack,
        input  dtack_n, berr_n, dir, rom_sel, periph_cs,
               sram_ce_n, sram_oe_n, sram_we_n
    );

    modport slave (
        input  as_n, r_wn, uds_n, lds_n, addr, periph_ack,
        output dtack_n, berr_n, dir, rom_sel, periph_cs,
               sram_ce_n, sram_oe_n, sram_we_n
    );

endinterface

// File: rtl/m68k_addr_decode.sv
// Combinational classification of a 68000 word address into a bus region.
module m68k_addr_decode
    import m68k_bus_pkg::*;
(
    input  logic [23:1] i_addr,
    output region_t     o_region
);

    logic [23:0] w_byte;

    assign w_byte = {i_addr, 1'b0};

    always_comb begin
        if ((w_byte & ROM_MASK) == ROM_BASE) begin
            o_region = REG_ROM;
        end else if ((w_byte & SRAM_MASK) == SRAM_BASE) begin
            o_region = REG_SRAM;
        end else if ((w_byte & PERIPH_MASK) == PERIPH_BASE) begin
            o_region = REG_PERIPH;
        end else begin
            o_region = REG_UNMAPPED;
        end
    end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus-cycle sequencer: decodes each AS cycle, inserts region wait
// states and drives registered DTACKn/BERRn, buffer direction and strobes.
module m68k_bus_ctrl
    import m68k_bus_pkg::*;
#(
    parameter int unsigned ROM_WAIT       = DEF_ROM_WAIT,
    parameter int unsigned SRAM_WAIT      = DEF_SRAM_WAIT,
    parameter int unsigned PERIPH_TIMEOUT = DEF_PERIPH_TIMEOUT
) (
    input  logic            clk12,
    input  logic            rst,
    m68k_bus_ctrl_if.slave  bus
);

    localparam logic [7:0] LP_ROM_WAIT  = 8'(ROM_WAIT);
    localparam logic [7:0] LP_SRAM_WAIT = 8'(SRAM_WAIT);
    localparam logic [7:0] LP_TIMEOUT   = 8'(PERIPH_TIMEOUT);

    logic       r_as_meta;
    logic       r_as_s;
    logic       r_armed;
    state_t     r_state;
    state_t     w_state_nx;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nx;
    logic [7:0] w_cnt_inc;
    region_t    r_region;
    region_t    w_region;
    region_t    w_cyc_region;
    logic       r_rw;
    logic       w_cyc_rw;
    bus_out_t   r_out;
    bus_out_t   w_out_nx;

    m68k_addr_decode u_decode (
        .i_addr   (bus.addr),
        .o_region (w_region)
    );

    always_ff @(posedge clk12) begin
        r_as_meta <= bus.as_n;
        r_as_s    <= r_as_meta;
    end

    // The sync flops survive reset, so a cycle still low after reset is
    // ignored until AS has been seen high again.
    always_ff @(posedge clk12) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_region <= REG_UNMAPPED;
            r_rw     <= 1'b1;
            r_armed  <= 1'b0;
            r_out    <= OUT_IDLE;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_armed <= r_armed | r_as_s;
            r_out   <= w_out_nx;
            if (r_state == ST_DECODE) begin
                r_region <= w_region;
                r_rw     <= bus.r_wn;
            end
        end
    end

    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nx = '0;
                if (!r_as_s && r_armed) begin
                    w_state_nx = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (r_as_s) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    case (w_region)
                        REG_ROM: begin
                            w_cnt_nx   = LP_ROM_WAIT;
                            w_state_nx = bus.r_wn ? ST_WAIT : ST_ERR;
                        end
                        REG_SRAM: begin
                            w_cnt_nx   = LP_SRAM_WAIT;
                            w_state_nx = ST_WAIT;
                        end
                        REG_PERIPH: begin
                            w_cnt_nx   = '0;
                            w_state_nx = ST_WAIT;
                        end
                        default: w_state_nx = ST_ERR;
                    endcase
                end
            end
            ST_WAIT: begin
                if (r_as_s) begin
                    w_state_nx = ST_IDLE;
                end else if (r_region == REG_PERIPH) begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (bus.periph_ack) begin
                        w_state_nx = ST_ACK;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc >= LP_TIMEOUT) begin
                            w_state_nx = ST_ERR;
                        end
                    end
                end else if (r_cnt == '0) begin
                    w_state_nx = ST_ACK;
                end else begin
                    w_cnt_nx = r_cnt - 8'd1;
                end
            end
            ST_ACK, ST_ERR: begin
                if (r_as_s) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign w_cyc_region = (r_state == ST_DECODE) ? w_region : r_region;
    assign w_cyc_rw     = (r_state == ST_DECODE) ? bus.r_wn : r_rw;

    // Outputs are derived from the next state so they register together
    // with the state transition.
    always_comb begin
        w_out_nx = OUT_IDLE;
        case (w_state_nx)
            ST_WAIT, ST_ACK: begin
                case (w_cyc_region)
                    REG_ROM:    w_out_nx.rom_sel   = 1'b1;
                    REG_PERIPH: w_out_nx.periph_cs = 1'b1;
                    REG_SRAM: begin
                        w_out_nx.sram_ce_n = 1'b0;
                        if (w_cyc_rw) begin
                            w_out_nx.sram_oe_n = 1'b0;
                        end else begin
                            w_out_nx.sram_we_n = {bus.uds_n, bus.lds_n};
                        end
                    end
                    default: ;
                endcase
                if (w_state_nx == ST_ACK) begin
                    w_out_nx.dtack_n = 1'b0;
                    w_out_nx.dir     = w_cyc_rw;
                end
            end
            ST_ERR:  w_out_nx.berr_n = 1'b0;
            default: ;
        endcase
    end

    assign bus.dtack_n   = r_out.dtack_n;
    assign bus.berr_n    = r_out.berr_n;
    assign bus.dir       = r_out.dir;
    assign bus.rom_sel   = r_out.rom_sel;
    assign bus.periph_cs = r_out.periph_cs;
    assign bus.sram_ce_n = r_out.sram_ce_n;
    assign bus.sram_oe_n = r_out.sram_oe_n;
    assign bus.sram_we_n = r_out.sram_we_n;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed bench for m68k_bus_ctrl: one default instance and one with
// SRAM_WAIT=4 / PERIPH_TIMEOUT=3, both driven with the same CPU stimulus.
module tb_m68k_bus_ctrl;

    logic clk12;
    logic rst;
    int unsigned n_checks;
    int unsigned n_errors;

    m68k_bus_ctrl_if bus0 ();
    m68k_bus_ctrl_if bus1 ();

    m68k_bus_ctrl dut0 (
        .clk12 (clk12),
        .rst   (rst),
        .bus   (bus0)
    );

    m68k_bus_ctrl #(
        .ROM_WAIT       (0),
        .SRAM_WAIT      (4),
        .PERIPH_TIMEOUT (3)
    ) dut1 (
        .clk12 (clk12),
        .rst   (rst),
        .bus   (bus1)
    );

    // {dtack_n, berr_n, dir, rom_sel, periph_cs, sram_ce_n, sram_oe_n, sram_we_n[1:0]}
    localparam logic [8:0] P_IDLE      = 9'b110001111;
    localparam logic [8:0] P_ROM_WAIT  = 9'b110101111;
    localparam logic [8:0] P_ROM_ACK   = 9'b011101111;
    localparam logic [8:0] P_SRD_WAIT  = 9'b110000011;
    localparam logic [8:0] P_SRD_ACK   = 9'b011000011;
    localparam logic [8:0] P_SWR_WAIT  = 9'b110000101;
    localparam logic [8:0] P_SWR_ACK   = 9'b010000101;
    localparam logic [8:0] P_PER_WAIT  = 9'b110011111;
    localparam logic [8:0] P_PER_ACK   = 9'b011011111;
    localparam logic [8:0] P_ERR       = 9'b100001111;

    logic [8:0] w_o0;
    logic [8:0] w_o1;

    assign w_o0 = {bus0.dtack_n, bus0.berr_n, bus0.dir, bus0.rom_sel, bus0.periph_cs,
                   bus0.sram_ce_n, bus0.sram_oe_n, bus0.sram_we_n};
    assign w_o1 = {bus1.dtack_n, bus1.berr_n, bus1.dir, bus1.rom_sel, bus1.periph_cs,
                   bus1.sram_ce_n, bus1.sram_oe_n, bus1.sram_we_n};

    initial clk12 = 1'b0;
    always #5 clk12 = ~clk12;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk12);
            #1;
        end
    endtask

    task automatic set_as(input logic v);
        bus0.as_n = v;
        bus1.as_n = v;
    endtask

    task automatic set_ack(input logic v);
        bus0.periph_ack = v;
        bus1.periph_ack = v;
    endtask

    task automatic set_cyc(input logic [23:0] a, input logic rw, input logic uds, input logic lds);
        bus0.addr  = a[23:1];
        bus1.addr  = a[23:1];
        bus0.r_wn  = rw;
        bus1.r_wn  = rw;
        bus0.uds_n = uds;
        bus1.uds_n = uds;
        bus0.lds_n = lds;
        bus1.lds_n = lds;
    endtask

    // Deassert AS: as_s rises 2 edges later, outputs idle on the 3rd edge.
    task automatic release_as(input string tag);
        set_as(1'b1);
        tick(3);
        check({tag, "_idle0"}, w_o0, P_IDLE);
        check({tag, "_idle1"}, w_o1, P_IDLE);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        set_as(1'b0);
        set_ack(1'b0);
        set_cyc(24'h000010, 1'b1, 1'b0, 1'b0);

        // Reset with AS held low
        tick(4);
        check("rst_out0", w_o0, P_IDLE);
        check("rst_out1", w_o1, P_IDLE);
        rst = 1'b0;
        tick(4);
        check("post_rst_no_accept", w_o0, P_IDLE);
        set_as(1'b1);
        tick(3);

        // ROM read: DECODE at edge 3, WAIT at 4, ACK at 5
        set_as(1'b0);
        tick(4);
        check("rom_wait", w_o0, P_ROM_WAIT);
        tick(1);
        check("rom_ack0", w_o0, P_ROM_ACK);
        check("rom_ack1", w_o1, P_ROM_ACK);
        set_as(1'b1);
        tick(2);
        check("rom_hold", w_o0, P_ROM_ACK);
        tick(1);
        check("rom_rel", w_o0, P_IDLE);

        // SRAM read, SRAM_WAIT=1: ACK one edge later than ROM
        set_cyc(24'h100000, 1'b1, 1'b0, 1'b0);
        set_as(1'b0);
        tick(4);
        check("srd_wait_entry", w_o0, P_SRD_WAIT);
        tick(1);
        check("srd_wait_last", w_o0, P_SRD_WAIT);
        tick(1);
        check("srd_ack", w_o0, P_SRD_ACK);
        release_as("srd");

        // SRAM write, upper byte only
        set_cyc(24'h100002, 1'b0, 1'b0, 1'b1);
        set_as(1'b0);
        tick(4);
        check("swr_wait", w_o0, P_SWR_WAIT);
        tick(2);
        check("swr_ack", w_o0, P_SWR_ACK);
        release_as("swr");

        // Peripheral read, ack pulsed 5 cycles after periph_cs
        set_cyc(24'hF00004, 1'b1, 1'b0, 1'b0);
        set_as(1'b0);
        tick(4);
        check("per_wait0", w_o0, P_PER_WAIT);
        check("per_wait1", w_o1, P_PER_WAIT);
        tick(2);
        check("per_t3_before", w_o1, P_PER_WAIT);
        tick(1);
        check("per_t3_timeout", w_o1, P_ERR);
        check("per_still_wait", w_o0, P_PER_WAIT);
        tick(2);
        check("per_pre_ack", w_o0, P_PER_WAIT);
        set_ack(1'b1);
        tick(1);
        set_ack(1'b0);
        check("per_ack", w_o0, P_PER_ACK);
        release_as("per");

        // Peripheral with no ack: 255 WAIT cycles then BERR
        set_as(1'b0);
        tick(4);
        check("pto_wait_entry", w_o0, P_PER_WAIT);
        tick(254);
        check("pto_wait_last", w_o0, P_PER_WAIT);
        tick(1);
        check("pto_berr", w_o0, P_ERR);
        tick(3);
        check("pto_berr_hold", w_o0, P_ERR);
        release_as("pto");

        // Unmapped read: BERR the edge after DECODE
        set_cyc(24'h200000, 1'b1, 1'b0, 1'b0);
        set_as(1'b0);
        tick(3);
        check("unm_decode", w_o0, P_IDLE);
        tick(1);
        check("unm_berr", w_o0, P_ERR);
        tick(4);
        check("unm_hold", w_o0, P_ERR);
        release_as("unm");

        // ROM write is a bus error
        set_cyc(24'h000000, 1'b0, 1'b0, 1'b0);
        set_as(1'b0);
        tick(4);
        check("romwr_berr", w_o0, P_ERR);
        check("romwr_berr1", w_o1, P_ERR);
        release_as("romwr");

        // Abort during SRAM WAIT on the SRAM_WAIT=4 instance
        set_cyc(24'h100000, 1'b1, 1'b0, 1'b0);
        set_as(1'b0);
        tick(4);
        check("abt_wait", w_o1, P_SRD_WAIT);
        set_as(1'b1);
        tick(2);
        check("abt_still_wait", w_o1, P_SRD_WAIT);
        tick(1);
        check("abt_idle", w_o1, P_IDLE);
        tick(2);
        check("abt_no_dtack", w_o1, P_IDLE);
        tick(1);
        check("abt_no_dtack2", w_o1, P_IDLE);

        // Back-to-back ROM cycles with AS high for one clock
        set_cyc(24'h000010, 1'b1, 1'b0, 1'b0);
        set_as(1'b0);
        tick(5);
        check("b2b_ack1", w_o0, P_ROM_ACK);
        set_as(1'b1);
        tick(1);
        set_as(1'b0);
        tick(2);
        check("b2b_gap", w_o0, P_IDLE);
        tick(3);
        check("b2b_ack2", w_o0, P_ROM_ACK);
        release_as("b2b");

        // Ack coincident with timeout edge (PERIPH_TIMEOUT=3): ack wins
        set_cyc(24'hF00004, 1'b1, 1'b0, 1'b0);
        set_as(1'b0);
        tick(6);
        set_ack(1'b1);
        tick(1);
        set_ack(1'b0);
        check("tie_ack", w_o1, P_PER_ACK);
        release_as("tie");

        // Reset during ACK
        set_cyc(24'h000010, 1'b1, 1'b0, 1'b0);
        set_as(1'b0);
        tick(5);
        check("racks_ack", w_o0, P_ROM_ACK);
        rst = 1'b1;
        tick(1);
        check("racks_rst0", w_o0, P_IDLE);
        check("racks_rst1", w_o1, P_IDLE);
        rst = 1'b0;
        tick(5);
        check("racks_no_reaccept", w_o0, P_IDLE);
        set_as(1'b1);
        tick(3);
        set_as(1'b0);
        tick(5);
        check("racks_recover", w_o0, P_ROM_ACK);
        release_as("racks");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
